// File: rtl/libv_wrr_pkg.sv
// -----------------------------------------------------------------------------
// libv_wrr_pkg
// Shared constants for the weighted packet-aware round-robin arbiter.
//   DEF_W     : default number of requestors
//   DEF_WGT_W : default per-requestor weight width
// -----------------------------------------------------------------------------
package libv_wrr_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_WGT_W = 4;

endpackage : libv_wrr_pkg

// File: rtl/libv_wrr_if.sv
// -----------------------------------------------------------------------------
// libv_wrr_if
// Request/grant bundle between requestors (master) and the arbiter (slave).
//   req       : per-requestor request
//   ack       : granted beat accepted this cycle
//   last      : accepted beat ends the current packet
//   weight    : packets per turn, weight[i] = bits [i*WGT_W +: WGT_W]
//   gnt       : one-hot grant or zero
//   gnt_enc   : binary index of gnt, 0 when gnt is zero
//   locked    : a packet is in progress
//   owner_vld : a turn is in progress
// -----------------------------------------------------------------------------
interface libv_wrr_if
    import libv_wrr_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WGT_W = DEF_WGT_W
);
    localparam int EW = $clog2(W);

    logic [W-1:0]       req;
    logic               ack;
    logic               last;
    logic [W*WGT_W-1:0] weight;
    logic [W-1:0]       gnt;
    logic [EW-1:0]      gnt_enc;
    logic               locked;
    logic               owner_vld;

    modport master (
        output req, ack, last, weight,
        input  gnt, gnt_enc, locked, owner_vld
    );

    modport slave (
        input  req, ack, last, weight,
        output gnt, gnt_enc, locked, owner_vld
    );

endinterface : libv_wrr_if

// File: rtl/libv_wrr_rr_pick.sv
// -----------------------------------------------------------------------------
// libv_rr_pick
// Combinational round-robin pick: first set bit of req at or above the
// one-hot pointer, wrapping to the lowest set bit below it.
//   req : W-bit request vector
//   ptr : one-hot priority pointer
//   sel : one-hot selection (zero when req is zero)
//   enc : binary index of sel (zero when sel is zero)
// -----------------------------------------------------------------------------
module libv_rr_pick
    import libv_wrr_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int EW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    input  logic [W-1:0]  ptr,
    output logic [W-1:0]  sel,
    output logic [EW-1:0] enc
);

    logic [W-1:0] mask;
    logic [W-1:0] hi;
    logic [W-1:0] cand;

    always_comb begin
        // Inclusive-left mask: the pointer bit and everything above it.
        mask = ~(ptr - W'(1));
        hi   = req & mask;
        cand = (|hi) ? hi : req;
        // Isolate the lowest set bit.
        sel  = cand & (~cand + W'(1));
        enc  = '0;
        for (int i = 0; i < W; i++) begin
            if (sel[i]) enc = enc | EW'(i);
        end
    end

endmodule : libv_rr_pick

// File: rtl/libv_wrr.sv
// -----------------------------------------------------------------------------
// libv_wrr
// Weighted, packet-aware round-robin arbiter. Each requestor wins a turn of up
// to weight[i] packets (0 treated as 1); the grant is locked to the owner
// while a packet is in progress. Grant is combinational.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : libv_wrr_if slave side (req/ack/last/weight in, gnt/gnt_enc/
//         locked/owner_vld out)
// -----------------------------------------------------------------------------
module libv_wrr
    import libv_wrr_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WGT_W = DEF_WGT_W
) (
    input  logic      clk,
    input  logic      rst,
    libv_wrr_if.slave bus
);

    localparam int EW = $clog2(W);

    logic [W-1:0]     ptr_r;
    logic             own_r;
    logic [EW-1:0]    owner_r;
    logic             lock_r;
    logic [WGT_W-1:0] cred_r;

    logic [W-1:0]     own_oh;
    logic             own_req;
    logic             hold;
    logic             forfeit;
    logic [W-1:0]     fwd_ptr;
    logic [W-1:0]     pick_ptr;
    logic [W-1:0]     pick_sel;
    logic [EW-1:0]    pick_enc;
    logic [W-1:0]     gnt;
    logic [EW-1:0]    gnt_enc;
    logic [WGT_W-1:0] wsel;
    logic [WGT_W-1:0] cred_base;
    logic             upd;
    logic [W-1:0]     gnt_rll;

    always_comb begin
        own_oh  = W'(1) << owner_r;
        own_req = bus.req[owner_r];
        hold    = own_r && (lock_r || own_req);
        // Idle owner between packets gives up the rest of its turn at once.
        forfeit = own_r && !lock_r && !own_req;
        fwd_ptr = {own_oh[W-2:0], own_oh[W-1]};
        pick_ptr = forfeit ? fwd_ptr : ptr_r;
    end

    libv_rr_pick #(.W(W), .EW(EW)) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .sel (pick_sel),
        .enc (pick_enc)
    );

    always_comb begin
        if (hold) begin
            // Locked owner that drops req produces a bubble, not a handover.
            gnt     = own_oh & bus.req;
            gnt_enc = own_req ? owner_r : '0;
        end else begin
            gnt     = pick_sel;
            gnt_enc = pick_enc;
        end
        wsel      = bus.weight[gnt_enc*WGT_W +: WGT_W];
        // Weight only matters when a new turn starts; a held turn keeps its count.
        cred_base = hold ? cred_r : ((wsel == '0) ? WGT_W'(1) : wsel);
        upd       = bus.ack && (|gnt);
        gnt_rll   = {gnt[W-2:0], gnt[W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= W'(1);
            own_r   <= 1'b0;
            owner_r <= '0;
            lock_r  <= 1'b0;
            cred_r  <= '0;
        end else begin
            if (forfeit) begin
                own_r  <= 1'b0;
                ptr_r  <= fwd_ptr;
                cred_r <= '0;
            end
            // An accepted beat overrides the forfeit bookkeeping above.
            if (upd) begin
                if (!bus.last) begin
                    own_r   <= 1'b1;
                    owner_r <= gnt_enc;
                    lock_r  <= 1'b1;
                    cred_r  <= cred_base;
                end else if (cred_base == WGT_W'(1)) begin
                    own_r  <= 1'b0;
                    lock_r <= 1'b0;
                    ptr_r  <= gnt_rll;
                end else begin
                    own_r   <= 1'b1;
                    owner_r <= gnt_enc;
                    lock_r  <= 1'b0;
                    cred_r  <= cred_base - WGT_W'(1);
                end
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_enc   = gnt_enc;
    assign bus.locked    = lock_r;
    assign bus.owner_vld = own_r;

endmodule : libv_wrr

// File: tb/tb_libv_wrr.sv
// Directed bench for libv_wrr with W=4. Each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares mid-cycle.
module tb_libv_wrr;

    localparam int W     = 4;
    localparam int WGT_W = 4;

    typedef struct {
        int         id;
        logic [3:0] gnt;
        logic [1:0] enc;
        logic       lk;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   id    = 0;

    always #5 clk = ~clk;

    libv_wrr_if #(.W(W), .WGT_W(WGT_W)) bus ();

    libv_wrr #(.W(W), .WGT_W(WGT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one cycle of inputs and record what the outputs must be during it.
    task automatic step(input logic [3:0] r, input logic a, input logic l,
                        input logic [3:0] eg, input logic [1:0] ee,
                        input logic elk, input logic eov);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.ack  = a;
        bus.last = l;
        e.id = id; e.gnt = eg; e.enc = ee; e.lk = elk; e.ov = eov;
        q.push_back(e);
        id++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.req  = '0;
        bus.ack  = 1'b0;
        bus.last = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (bus.gnt !== e.gnt || bus.gnt_enc !== e.enc ||
                bus.locked !== e.lk || bus.owner_vld !== e.ov) begin
                bad++;
                $display("FAIL vec%0d: got gnt=%b enc=%0d locked=%b owner_vld=%b, want gnt=%b enc=%0d locked=%b owner_vld=%b",
                         e.id, bus.gnt, bus.gnt_enc, bus.locked, bus.owner_vld,
                         e.gnt, e.enc, e.lk, e.ov);
            end
        end
    end

    initial begin
        bus.req    = '0;
        bus.ack    = 1'b0;
        bus.last   = 1'b0;
        bus.weight = 16'h1111;
        do_reset();

        // Reset state with no requests.
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Plain round robin, all weights 1.
        step(4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);

        // Weight 3 on bit 0: three packets then hand over.
        do_reset();
        bus.weight = 16'h1113;
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1);
        step(4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Lock and bubble.
        do_reset();
        bus.weight = 16'h1111;
        step(4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);

        // Forfeit: bit 0 leaves with credit, pointer moves past it.
        do_reset();
        bus.weight = 16'h1114;
        step(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1);

        // Forfeit without ack still releases ownership next cycle.
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1);
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);

        // ack with no request changes nothing; pointer stays at bit 0.
        do_reset();
        bus.weight = 16'h1111;
        for (int i = 0; i < 5; i++)
            step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Weight 0 behaves as 1.
        do_reset();
        bus.weight = 16'h1011;
        step(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0);

        // Maximum weight 15 keeps the turn for 15 packets.
        do_reset();
        bus.weight = 16'h111F;
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++)
            step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1);
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);

        // Reset while locked on bit 3.
        do_reset();
        bus.weight = 16'h1111;
        step(4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
        do_reset();
        step(4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_libv_wrr
